logic_reduce_pipe: RTL and testbench

//  Parametrised, registered N-input reduction gate with run-time mode select
//  (AND/OR/NAND/NOR/XOR/XNOR). Successor to the fixed 4-input OR block.

---
 rtl/logic_reduce_pipe.sv | 100 ++++++++++
 tb/tb_logic_reduce_pipe.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/logic_reduce_pipe.sv
// Registered N-input reduction gate with run-time mode select, a one-entry
// valid/ready output stage and a saturating count of 0->1 result edges.
module logic_reduce_pipe #(
    parameter int N_IN  = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N_IN-1:0]  in_data,
    input  logic [2:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_result,
    output logic             out_err,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] rise_count
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    // Reserved modes (6/7) reduce to 0; the error flag is derived separately.
    function automatic logic reduce_f(input logic [2:0] mode, input logic [N_IN-1:0] d);
        logic r;
        case (mode)
            3'd0:    r = &d;
            3'd1:    r = |d;
            3'd2:    r = ~&d;
            3'd3:    r = ~|d;
            3'd4:    r = ^d;
            3'd5:    r = ~^d;
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    logic             out_valid_d,  out_valid_q;
    logic             out_result_d, out_result_q;
    logic             out_err_d,    out_err_q;
    logic             prev_res_d,   prev_res_q;
    logic [CNT_W-1:0] rise_count_d, rise_count_q;
    logic             accept_s;
    logic             new_res_s;
    logic [CNT_W-1:0] cnt_base_s;

    assign in_ready   = ~out_valid_q | out_ready;
    assign out_valid  = out_valid_q;
    assign out_result = out_result_q;
    assign out_err    = out_err_q;
    assign rise_count = rise_count_q;

    // Next-state: output stage, last accepted result and rise counter.
    always_comb begin
        accept_s     = in_valid & in_ready;
        new_res_s    = reduce_f(in_mode, in_data);
        out_valid_d  = out_valid_q;
        out_result_d = out_result_q;
        out_err_d    = out_err_q;
        prev_res_d   = prev_res_q;
        cnt_base_s   = cnt_clr ? {CNT_W{1'b0}} : rise_count_q;
        rise_count_d = cnt_base_s;

        if (accept_s) begin
            out_valid_d  = 1'b1;
            out_result_d = new_res_s;
            out_err_d    = (in_mode > 3'd5);
            prev_res_d   = new_res_s;
        end else if (out_ready) begin
            out_valid_d  = 1'b0;
        end else begin
            out_valid_d  = out_valid_q;
        end

        // Clear is applied first so a same-cycle rise lands on a count of 1.
        if (accept_s && new_res_s && !prev_res_q && (cnt_base_s != CNT_MAX)) begin
            rise_count_d = cnt_base_s + CNT_W'(1);
        end else begin
            rise_count_d = cnt_base_s;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q  <= 1'b0;
            out_result_q <= 1'b0;
            out_err_q    <= 1'b0;
            prev_res_q   <= 1'b0;
            rise_count_q <= {CNT_W{1'b0}};
        end else begin
            out_valid_q  <= out_valid_d;
            out_result_q <= out_result_d;
            out_err_q    <= out_err_d;
            prev_res_q   <= prev_res_d;
            rise_count_q <= rise_count_d;
        end
    end

endmodule

// File: tb/tb_logic_reduce_pipe.sv
// Scoreboard bench for logic_reduce_pipe: one instance with an 8-bit counter
// and one with a 2-bit counter share the same stimulus.
module tb_logic_reduce_pipe;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [3:0] in_data;
    logic [2:0] in_mode;
    logic       out_ready;
    logic       cnt_clr;

    logic       in_ready_a, out_valid_a, out_result_a, out_err_a;
    logic [7:0] rise_a;
    logic       in_ready_b, out_valid_b, out_result_b, out_err_b;
    logic [1:0] rise_b;

    int n_cmp = 0;
    int n_bad = 0;

    logic       m_valid;
    logic       m_prev;
    int         m_cnt_a;
    int         m_cnt_b;
    logic [1:0] sb_q[$];

    always #5 clk = ~clk;

    logic_reduce_pipe #(.N_IN(4), .CNT_W(8)) dut_a (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_a),
        .in_data(in_data), .in_mode(in_mode), .out_valid(out_valid_a),
        .out_ready(out_ready), .out_result(out_result_a), .out_err(out_err_a),
        .cnt_clr(cnt_clr), .rise_count(rise_a)
    );

    logic_reduce_pipe #(.N_IN(4), .CNT_W(2)) dut_b (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_b),
        .in_data(in_data), .in_mode(in_mode), .out_valid(out_valid_b),
        .out_ready(out_ready), .out_result(out_result_b), .out_err(out_err_b),
        .cnt_clr(cnt_clr), .rise_count(rise_b)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Expected result built from the count of set bits.
    function automatic logic [1:0] model_f(input logic [2:0] m, input logic [3:0] d);
        int ones;
        logic r;
        ones = 0;
        for (int i = 0; i < 4; i++) ones += int'(d[i]);
        case (m)
            3'd0:    r = (ones == 4);
            3'd1:    r = (ones != 0);
            3'd2:    r = (ones != 4);
            3'd3:    r = (ones == 0);
            3'd4:    r = (ones % 2 == 1);
            3'd5:    r = (ones % 2 == 0);
            default: r = 1'b0;
        endcase
        return {(m > 3'd5), r};
    endfunction

    task automatic check_outputs();
        logic [1:0] exp_v;
        check_val("out_valid", {31'd0, out_valid_a}, {31'd0, m_valid});
        check_val("out_valid_b", {31'd0, out_valid_b}, {31'd0, m_valid});
        if (m_valid) begin
            exp_v = (sb_q.size() > 0) ? sb_q[0] : 2'bxx;
            check_val("out_result", {31'd0, out_result_a}, {31'd0, exp_v[0]});
            check_val("out_err", {31'd0, out_err_a}, {31'd0, exp_v[1]});
        end
        check_val("rise_count8", {24'd0, rise_a}, m_cnt_a);
        check_val("rise_count2", {30'd0, rise_b}, m_cnt_b);
    endtask

    // One clock of stimulus; called on the falling edge.
    task automatic step(input logic v, input logic [2:0] m, input logic [3:0] d,
                        input logic ordy, input logic clr);
        logic exp_rdy, acc, hs;
        logic [1:0] ev;
        in_valid  = v;
        in_mode   = m;
        in_data   = d;
        out_ready = ordy;
        cnt_clr   = clr;
        #1;
        exp_rdy = ~m_valid | ordy;
        check_val("in_ready", {31'd0, in_ready_a}, {31'd0, exp_rdy});
        acc = v & exp_rdy;
        hs  = m_valid & ordy;
        ev  = model_f(m, d);
        @(posedge clk);
        #1;
        if (hs && sb_q.size() > 0) sb_q.delete(0);
        if (acc) sb_q.push_back(ev);
        m_valid = acc | (m_valid & ~ordy);
        if (clr) begin
            m_cnt_a = 0;
            m_cnt_b = 0;
        end
        if (acc && ev[0] && !m_prev) begin
            if (m_cnt_a < 255) m_cnt_a++;
            if (m_cnt_b < 3) m_cnt_b++;
        end
        if (acc) m_prev = ev[0];
        check_outputs();
        @(negedge clk);
    endtask

    task automatic do_reset(input int cycles);
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        cnt_clr   = 1'b0;
        repeat (cycles) @(posedge clk);
        #1;
        rst = 1'b0;
        m_valid = 1'b0;
        m_prev  = 1'b0;
        m_cnt_a = 0;
        m_cnt_b = 0;
        sb_q.delete();
        check_val("rst_out_valid", {31'd0, out_valid_a}, 32'd0);
        check_val("rst_out_result", {31'd0, out_result_a}, 32'd0);
        check_val("rst_out_err", {31'd0, out_err_a}, 32'd0);
        check_val("rst_rise_count", {24'd0, rise_a}, 32'd0);
        check_val("rst_in_ready", {31'd0, in_ready_a}, 32'd1);
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0; in_data = 4'd0; in_mode = 3'd0;
        out_ready = 1'b0; cnt_clr = 1'b0;
        m_valid = 1'b0; m_prev = 1'b0; m_cnt_a = 0; m_cnt_b = 0;
        @(negedge clk);
        do_reset(2);

        // OR over a walking one
        step(1'b1, 3'd1, 4'b0000, 1'b1, 1'b0);
        step(1'b1, 3'd1, 4'b1000, 1'b1, 1'b0);
        step(1'b1, 3'd1, 4'b0100, 1'b1, 1'b0);
        step(1'b1, 3'd1, 4'b0010, 1'b1, 1'b0);
        step(1'b1, 3'd1, 4'b0001, 1'b1, 1'b0);
        check_val("walk_rise", {24'd0, rise_a}, 32'd1);
        step(1'b0, 3'd0, 4'b0000, 1'b1, 1'b0);

        // every mode on 1011, then reserved modes
        for (int m = 0; m < 8; m++) step(1'b1, 3'(m), 4'b1011, 1'b1, 1'b0);
        step(1'b0, 3'd0, 4'b0000, 1'b1, 1'b0);

        // stall: accept 1111/AND, hold three cycles with a pending new input
        step(1'b1, 3'd0, 4'b1111, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 3'd0, 4'b0111, 1'b0, 1'b0);
            check_val("stall_result", {31'd0, out_result_a}, 32'd1);
        end
        step(1'b1, 3'd0, 4'b0111, 1'b1, 1'b0);
        check_val("replace_result", {31'd0, out_result_a}, 32'd0);
        check_val("replace_valid", {31'd0, out_valid_a}, 32'd1);
        step(1'b0, 3'd0, 4'b0000, 1'b1, 1'b0);

        // saturation: alternate 0/1 results for five rises
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 3'd1, 4'b0000, 1'b1, 1'b0);
            step(1'b1, 3'd1, 4'b0110, 1'b1, 1'b0);
        end
        check_val("sat_count2", {30'd0, rise_b}, 32'd3);
        step(1'b1, 3'd1, 4'b0000, 1'b1, 1'b0);
        step(1'b1, 3'd1, 4'b0001, 1'b1, 1'b1);
        check_val("clr_rise_count2", {30'd0, rise_b}, 32'd1);
        check_val("clr_rise_count8", {24'd0, rise_a}, 32'd1);

        // reset while a stalled result is pending
        step(1'b1, 3'd4, 4'b0001, 1'b0, 1'b0);
        step(1'b0, 3'd0, 4'b0000, 1'b0, 1'b0);
        do_reset(1);
        step(1'b1, 3'd0, 4'b1111, 1'b1, 1'b0);
        check_val("post_rst_rise", {24'd0, rise_a}, 32'd1);
        step(1'b0, 3'd0, 4'b0000, 1'b1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
